// File: rtl/seq_pkg.sv
// seq_pkg: opcodes, FSM states and instruction field positions shared by the sequencer.
package seq_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RS_BIT = 5;
    localparam int RD_BIT = 4;
    localparam int IMM_HI = 3;
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_READ, S_EXEC, S_WRITE, S_HALT} state_t;
endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational instruction decode into register selects, ALU op and write/halt flags.
module seq_decode
    import seq_pkg::*;
#(
    parameter logic [3:0] HALT_IMM = 4'hF
) (
    input  logic [7:0] ir,
    output logic       rs,
    output logic       rd,
    output logic [1:0] alu_op,
    output logic       is_write,
    output logic       is_halt
);
    logic [1:0] opcode;
    assign opcode   = ir[OPC_HI:OPC_LO];
    assign rs       = ir[RS_BIT];
    assign rd       = ir[RD_BIT];
    // ALU encodings coincide with opcodes: LDI is PASS, SYS is NOP
    assign alu_op   = opcode;
    assign is_write = opcode != OP_SYS;
    assign is_halt  = (opcode == OP_SYS) && (ir[IMM_HI:0] == HALT_IMM);
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/read/exec/write control FSM with program counter.
// Optional SEQ_PERF_CNT_EN adds a saturating retired-instruction counter output.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int         PC_W     = 4,
    parameter logic [3:0] HALT_IMM = 4'hF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [7:0]      instr_data,
    output logic            instr_ready,
    output logic [PC_W-1:0] pc,
    output logic            reg_read1,
    output logic            reg_read2,
    output logic            reg_case,
    output logic            check_write,
    output logic [1:0]      alu_op,
    output logic [7:0]      imm_out,
    output logic            busy,
    output logic            halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [7:0]      retired_cnt
`endif
);
    state_t     state;
    logic [7:0] ir;
    logic       d_rs, d_rd, d_wr, d_halt;
    logic [1:0] d_alu;
    // In IDLE decode the incoming byte so selects are registered at the accept edge
    seq_decode #(.HALT_IMM(HALT_IMM)) u_dec (
        .ir       ((state == S_IDLE) ? instr_data : ir),
        .rs       (d_rs),
        .rd       (d_rd),
        .alu_op   (d_alu),
        .is_write (d_wr),
        .is_halt  (d_halt)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            instr_ready <= 1'b1;
            reg_read1   <= 1'b0;
            reg_read2   <= 1'b0;
            reg_case    <= 1'b0;
            check_write <= 1'b0;
            alu_op      <= 2'b00;
            imm_out     <= 8'h00;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (instr_valid && instr_ready) begin
                    state       <= S_DECODE;
                    ir          <= instr_data;
                    pc          <= pc + 1'b1;
                    instr_ready <= 1'b0;
                    busy        <= 1'b1;
                    reg_read1   <= d_rs;
                    reg_read2   <= d_rd;
                    alu_op      <= d_alu;
                    imm_out     <= {4'b0, instr_data[IMM_HI:0]};
                end
                S_DECODE: if (d_halt) begin
                    state     <= S_HALT;
                    halted    <= 1'b1;
                    busy      <= 1'b0;
                    reg_read1 <= 1'b0;
                    reg_read2 <= 1'b0;
                    alu_op    <= 2'b00;
                    imm_out   <= 8'h00;
                end else begin
                    state <= S_READ;
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    state       <= S_WRITE;
                    check_write <= d_wr;
                    reg_case    <= !d_wr;
                end
                S_WRITE: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    check_write <= 1'b0;
                    reg_case    <= 1'b0;
                    reg_read1   <= 1'b0;
                    reg_read2   <= 1'b0;
                    alu_op      <= 2'b00;
                    imm_out     <= 8'h00;
                end
                default: ;
            endcase
        end
    end
`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            retired_cnt <= 8'h00;
        else if (state == S_WRITE && retired_cnt != 8'hFF)
            retired_cnt <= retired_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed stimulus, cycle-count reference model and a two-entry regfile/ALU.
module tb_instr_sequencer;
    logic       clk = 0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic [3:0] pc;
    logic       reg_read1, reg_read2, reg_case, check_write, busy, halted;
    logic [1:0] alu_op;
    logic [7:0] imm_out;
`ifdef SEQ_PERF_CNT_EN
    logic [7:0] retired_cnt;
`endif

    instr_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_ready(instr_ready), .pc(pc), .reg_read1(reg_read1), .reg_read2(reg_read2),
        .reg_case(reg_case), .check_write(check_write), .alu_op(alu_op), .imm_out(imm_out),
        .busy(busy), .halted(halted)
`ifdef SEQ_PERF_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cw_cnt = 0;
    int rc_cnt = 0;
    logic [7:0] rf [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: cycles since accept (0 = idle), halt flag, pc and retire count
    int         since = 0;
    bit         mhalt = 0;
    bit         armed = 0;
    logic [7:0] mir = 0;
    int         mpc = 0;
    int         mret = 0;

    always @(posedge clk) begin
        logic r_s, v_s;
        logic [7:0] d_s, res;
        logic [1:0] op;
        logic ib;
        r_s = reset; v_s = instr_valid; d_s = instr_data;
        if (check_write === 1'b1) begin
            res = (alu_op == 2'b00) ? rf[reg_read2] + rf[reg_read1] :
                  (alu_op == 2'b01) ? rf[reg_read2] - rf[reg_read1] : imm_out;
            rf[reg_read2] = res;
            cw_cnt++;
        end
        if (reg_case === 1'b1) rc_cnt++;
        if (r_s) begin
            since = 0; mhalt = 0; mpc = 0; mret = 0;
        end else if (mhalt) begin
        end else if (since == 0) begin
            if (v_s) begin since = 1; mir = d_s; mpc = (mpc + 1) % 16; end
        end else if (since == 1 && mir[7:6] == 2'b11 && mir[3:0] == 4'hF) begin
            mhalt = 1; since = 0;
        end else if (since == 4) begin
            since = 0; mret = (mret < 255) ? mret + 1 : 255;
        end else begin
            since++;
        end
        armed = 1;
        #1;
        op = mir[7:6];
        ib = since != 0;
        chk("instr_ready", instr_ready, !mhalt && since == 0);
        chk("busy", busy, ib);
        chk("halted", halted, mhalt);
        chk("pc", pc, mpc);
        chk("reg_read1", reg_read1, ib ? mir[5] : 1'b0);
        chk("reg_read2", reg_read2, ib ? mir[4] : 1'b0);
        chk("alu_op", alu_op, ib ? op : 2'b00);
        chk("imm_out", imm_out, ib ? {4'b0, mir[3:0]} : 8'h00);
        chk("check_write", check_write, since == 4 && op != 2'b11);
        chk("reg_case", reg_case, since == 4 && op == 2'b11);
`ifdef SEQ_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, mret);
`endif
    end

    task automatic run(input logic [7:0] d);
        int i;
        cw_cnt = 0; rc_cnt = 0;
        @(negedge clk); instr_valid = 1; instr_data = d;
        @(negedge clk); instr_valid = 0;
        for (i = 0; i < 10 && !(instr_ready || halted); i++) @(negedge clk);
        if (!(instr_ready || halted)) chk("completion_timeout", 0, 1);
    endtask

    initial begin
        reset = 1; instr_valid = 0; instr_data = 0;
        rf[0] = 8'd1; rf[1] = 8'd4;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1); chk("rst_pc", pc, 0);
        chk("rst_cw", check_write, 0); chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
        run(8'b00_0_1_0000);
        chk("add_r1", rf[1], 8'd5); chk("add_pulses", cw_cnt, 1); chk("add_pc", pc, 1);
        run(8'b10_0_0_0111);
        chk("ldi_r0", rf[0], 8'd7); chk("ldi_pulses", cw_cnt, 1);
        run(8'b01_0_1_0000);
        chk("sub_r1", rf[1], 8'hFE);
        run(8'b11_0_1_0011);
        chk("nop_r1", rf[1], 8'hFE); chk("nop_pulses", cw_cnt, 0); chk("nop_case", rc_cnt, 1);
        run(8'b11_0_0_1111);
        chk("halt_flag", halted, 1); chk("halt_busy", busy, 0);
        instr_valid = 1; instr_data = 8'b00_0_1_0000;
        repeat (5) @(negedge clk);
        chk("halt_pc_frozen", pc, 5); chk("halt_ready", instr_ready, 0); chk("halt_stuck", halted, 1);
        reset = 1; instr_valid = 1;
        @(negedge clk);
        reset = 0; instr_valid = 0;
        @(negedge clk);
        chk("post_halt_ready", instr_ready, 1); chk("post_halt_pc", pc, 0); chk("post_halt_h", halted, 0);
        cw_cnt = 0;
        instr_valid = 1; instr_data = 8'b00_0_1_0000;
        @(negedge clk); instr_valid = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (4) @(negedge clk);
        chk("mid_reset_pulses", cw_cnt, 0); chk("mid_reset_pc", pc, 0); chk("mid_reset_ready", instr_ready, 1);
        chk("mid_reset_r1", rf[1], 8'hFE);
        for (int k = 0; k < 16; k++) begin
            run(8'b10_0_0_0001);
            if (k == 14) chk("pc_15", pc, 15);
        end
        chk("pc_wrap", pc, 0);
        chk("pc_wrap_r0", rf[0], 8'd1);
`ifdef SEQ_PERF_CNT_EN
        chk("retired_16", retired_cnt, 16);
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
